alu_param: RTL and testbench

ALU_PARAM -- requirements
Module: alu_param

---
 rtl/alu_param.sv | 190 +++++++++++++++++++
 tb/tb_alu_param.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_param.sv
// Parameterised N-bit ALU with registered result/flags and a multi-cycle shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise F=3'b111 is a single-cycle op yielding zero.
module alu_param #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   F,
    output logic [N-1:0] Y,
    output logic [N-1:0] Y_hi,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic         busy,
    output logic         valid
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [N-1:0] y_q, y_d;
    logic [N-1:0] y_hi_q, y_hi_d;
    logic         z_q, z_d;
    logic         c_q, c_d;
    logic         v_q, v_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;

    logic [N-1:0] res_s;
    logic         c_s;
    logic         v_s;
    logic [N:0]   add_s;
    logic [N-1:0] sub_s;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(N);
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_nx_s;
`endif

    // Single-cycle datapath: result and flags for the op currently on F.
    always_comb begin
        res_s = '0;
        c_s   = 1'b0;
        v_s   = 1'b0;
        add_s = {1'b0, A} + {1'b0, B};
        sub_s = A - B;
        case (F)
            OP_AND: res_s = A & B;
            OP_OR:  res_s = A | B;
            OP_ADD: begin
                res_s = add_s[N-1:0];
                c_s   = add_s[N];
                v_s   = (A[N-1] == B[N-1]) && (add_s[N-1] != A[N-1]);
            end
            OP_SUB: begin
                res_s = sub_s;
                c_s   = (A >= B);
                v_s   = (A[N-1] != B[N-1]) && (sub_s[N-1] != A[N-1]);
            end
            OP_XOR: res_s = A ^ B;
            OP_SLT: res_s = ($signed(A) < $signed(B)) ? {{(N-1){1'b0}}, 1'b1} : '0;
            OP_SHL: begin
                if (32'(B) >= N) begin
                    res_s = '0;
                end else begin
                    res_s = A << B;
                end
            end
            OP_MUL: res_s = '0;
            default: res_s = '0;
        endcase
    end

    // Next-state: accept a start when idle, or advance the multiplier one step.
    always_comb begin
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_nx_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        if (busy_q) begin
            acc_d    = acc_nx_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(N-1)) begin
                y_d     = acc_nx_s[N-1:0];
                y_hi_d  = acc_nx_s[2*N-1:N];
                z_d     = (acc_nx_s == '0);
                c_d     = 1'b0;
                v_d     = (acc_nx_s[2*N-1:N] != '0);
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start && (F == OP_MUL)) begin
            mcand_d  = {{N{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (start) begin
            y_d     = res_s;
            y_hi_d  = '0;
            z_d     = (res_s == '0);
            c_d     = c_s;
            v_d     = v_s;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
`else
        busy_d = 1'b0;
        if (start) begin
            y_d     = res_s;
            y_hi_d  = '0;
            z_d     = (res_s == '0);
            c_d     = c_s;
            v_d     = v_s;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q      <= '0;
            y_hi_q   <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            y_q      <= y_d;
            y_hi_q   <= y_hi_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign Y     = y_q;
    assign Y_hi  = y_hi_q;
    assign Z     = z_q;
    assign C     = c_q;
    assign V     = v_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_alu_param.sv
// Directed self-checking bench for alu_param at N=4; MUL cases are built when ALU_MUL_EN is defined.
module tb_alu_param;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] A, B;
    logic [2:0]   F;
    logic [N-1:0] Y, Y_hi;
    logic         Z, C, V, busy, valid;

    int checks = 0;
    int errors = 0;

    alu_param #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .F(F),
        .Y(Y), .Y_hi(Y_hi), .Z(Z), .C(C), .V(V), .busy(busy), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all result outputs in one go: {Y_hi, Y, Z, C, V, busy, valid}
    task automatic check_all(input string tag, input logic [N-1:0] ey, input logic [N-1:0] eyh,
                             input logic ez, input logic ec, input logic ev,
                             input logic ebusy, input logic evalid);
        check({tag, ".Y"},     32'(Y),     32'(ey));
        check({tag, ".Y_hi"},  32'(Y_hi),  32'(eyh));
        check({tag, ".Z"},     32'(Z),     32'(ez));
        check({tag, ".C"},     32'(C),     32'(ec));
        check({tag, ".V"},     32'(V),     32'(ev));
        check({tag, ".busy"},  32'(busy),  32'(ebusy));
        check({tag, ".valid"}, 32'(valid), 32'(evalid));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
        F = f; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; A = 4'b0000; B = 4'b0000; F = 3'b000;
        tick();
        tick();
        check_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        issue(3'b010, 4'b0111, 4'b1001);
        check_all("add_wrap", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("add_wrap_hold", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        issue(3'b010, 4'b0111, 4'b0001);
        check_all("add_ovf", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(3'b011, 4'b0001, 4'b0010);
        check_all("sub_neg", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b011, 4'b0101, 4'b0011);
        check_all("sub_pos", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(3'b011, 4'b0111, 4'b1000);
        check_all("sub_ovf", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(3'b011, 4'b0110, 4'b0110);
        check_all("sub_eq", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        issue(3'b000, 4'b1100, 4'b1010);
        check_all("and", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b001, 4'b1100, 4'b1010);
        check_all("or", 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b100, 4'b1100, 4'b1010);
        check_all("xor", 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        issue(3'b101, 4'b1110, 4'b0001);
        check_all("slt_true", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b101, 4'b0001, 4'b1110);
        check_all("slt_false", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        issue(3'b110, 4'b0011, 4'b0010);
        check_all("shl2", 4'b1100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b110, 4'b0011, 4'b0100);
        check_all("shl_big", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b110, 4'b0001, 4'b0011);
        check_all("shl3", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef ALU_MUL_EN
        // 15*15 = 225 = 8'hE1; a start with F=AND during the second busy cycle must be ignored
        issue(3'b111, 4'b1111, 4'b1111);
        check_all("mul_t0", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        A = 4'b0000; B = 4'b0000;
        tick();
        check_all("mul_t1", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        F = 3'b000; A = 4'b1111; B = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        check_all("mul_t2_ign", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("mul_t3", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("mul_done", 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("mul_hold", 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        issue(3'b111, 4'b0011, 4'b0101);
        repeat (4) tick();
        check_all("mul_15", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b111, 4'b0000, 4'b0101);
        repeat (4) tick();
        check_all("mul_zero", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during the second busy cycle aborts the multiply
        issue(3'b111, 4'b0011, 4'b0101);
        tick();
        rst_n = 1'b0;
        tick();
        check_all("mul_rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            check("mul_rst_novalid", 32'(valid), 32'(1'b0));
        end
`else
        issue(3'b111, 4'b0011, 4'b0101);
        check_all("mul_off", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("mul_off_hold", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(3'b010, 4'b0111, 4'b0001);
        rst_n = 1'b0;
        tick();
        check_all("rst_after_op", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
`endif

        issue(3'b010, 4'b0001, 4'b0010);
        check_all("add_post_rst", 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset wins over a simultaneous start
        rst_n = 1'b0;
        issue(3'b001, 4'b1111, 4'b0000);
        check_all("rst_prio", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
